pipe_rxdet_seq: RTL and testbench
=================================

# pipe_rxdet_seq

Receiver-detect and power-state sequencer for the single-lane ECP3 PCIe PIPE PHY (x1 root complex). It drives the PHY's PowerDown, TxDetectRx_Loopback and TxElecIdle inputs, and consumes PhyStatus, RxStatus_0 and ffs_plol. It implements the Detect.Quiet → Detect.Active → P0 entry handshake and reports link-partner presence to the LTSSM/link layer above it.

## Interface
Parameters:
- QUIET_CYCLES, 1500000, Detect.Quiet dwell in PCLK cycles (12 ms at 125 MHz).
- TIMEOUT_CYCLES, 1024, maximum wait for a PhyStatus pulse after any PHY request.
- CNT_W, 21, timer width; must satisfy 2^CNT_W > max(QUIET_CYCLES, TIMEOUT_CYCLES).

Ports:
- PCLK  in  1  PIPE parallel clock; the only clock.
- RESET_n  in  1  asynchronous, active-low reset.
- link_en  in  1  level request from the link layer to detect a receiver and bring the lane up.
- ffs_plol  in  1  PHY PLL loss-of-lock; 1 = unlocked.
- PhyStatus  in  1  PHY completion pulse, or held high while the PHY is in reset.
- RxStatus_0  in  3  PHY status; 3'b011 = receiver detected.
- PowerDown  out  2  PIPE power state.
- TxDetectRx_Loopback  out  1  receiver-detect request.
- TxElecIdle_0  out  1  transmitter electrical-idle control.
- rx_present  out  1  level; link partner detected and lane in P0.
- det_done  out  1  one-cycle pulse on entry to LINK_UP.
- det_timeout  out  1  sticky; a PhyStatus wait expired. Cleared only by reset.
- det_attempts  out  8  saturating count of completed detect operations that found no receiver.
- state_o  out  3  current FSM state, for debug.

## Operation
- States: RST_WAIT, IDLE, QUIET, DETECT, DET_END, P0_REQ, LINK_UP.
- Reset values:
  - state = RST_WAIT, PowerDown = 2'b10 (P1), TxDetectRx_Loopback = 0, TxElecIdle_0 = 1.
  - rx_present = 0, det_done = 0, det_timeout = 0, det_attempts = 0.
- RST_WAIT: leave to IDLE once PhyStatus = 0 and ffs_plol = 0 in the same cycle.
- IDLE: when link_en = 1, go to QUIET and load the timer.
- QUIET: dwell exactly QUIET_CYCLES cycles, then go to DETECT. If link_en = 0, go to IDLE.
- DETECT:
  - TxDetectRx_Loopback = 1, PowerDown = P1, TxElecIdle_0 = 1; timer loaded with TIMEOUT_CYCLES.
  - On a PhyStatus = 1 cycle, latch found = (RxStatus_0 == 3'b011) and go to DET_END.
  - On timer expiry without PhyStatus, set det_timeout and go to DET_END with found = 0.
- DET_END:
  - TxDetectRx_Loopback = 0.
  - If found, go to P0_REQ.
  - Otherwise increment det_attempts (saturate at 255) and go to QUIET, or to IDLE if link_en = 0.
- P0_REQ:
  - PowerDown = 2'b00; TxElecIdle_0 stays 1; timer loaded with TIMEOUT_CYCLES.
  - On PhyStatus = 1, go to LINK_UP.
  - On timeout, set det_timeout, PowerDown back to P1, go to QUIET.
- LINK_UP:
  - rx_present = 1; TxElecIdle_0 = 1 (released by the LTSSM downstream, not by this block).
  - If link_en = 0, go to IDLE with PowerDown = P1 and rx_present = 0.
- link_en = 0 during DETECT or P0_REQ is deferred: the PHY handshake completes first, then the FSM exits toward IDLE.
- ffs_plol = 1 in any state other than RST_WAIT forces RST_WAIT next cycle. All outputs take their reset values except det_timeout and det_attempts. This has highest priority.
- PhyStatus and timer expiry in the same cycle: PhyStatus wins and det_timeout is not set.
- A PhyStatus pulse in IDLE, QUIET or LINK_UP is ignored.

## Timing
- All outputs are registered; each changes the cycle after the state transition that causes it.
- TxDetectRx_Loopback:
  - rises 1 cycle after the QUIET terminal count;
  - falls 1 cycle after the PhyStatus sample.
- PhyStatus → PowerDown = 2'b00 latency: 2 cycles (DETECT → DET_END → P0_REQ).
- PhyStatus in P0_REQ → rx_present and det_done: 1 cycle.
- Timer counts down from N−1 and expires at 0. Expiry is therefore cycle N after load, counting the load cycle as cycle 1.

## Structure
- Package pipe_pkg holds:
  - power-state constants PD_P0 = 2'b00, PD_P0S = 2'b01, PD_P1 = 2'b10, PD_P2 = 2'b11;
  - RXSTAT_RXDET = 3'b011;
  - the 3-bit state encoding, shared with the LTSSM debug mux.
- Sub-module pipe_timer: a CNT_W-bit loadable down-counter with a done flag, used for both the quiet and timeout intervals. Only one of the two runs at a time.

## Test plan
Bench parameters: QUIET_CYCLES = 8, TIMEOUT_CYCLES = 16.
- Reset release with PhyStatus held high 5 cycles, then link_en = 1 → stays in RST_WAIT until PhyStatus falls; TxDetectRx_Loopback rises exactly 8 cycles after QUIET entry.
- DETECT, PHY pulses PhyStatus with RxStatus_0 = 3'b011, then acks P0 after 3 cycles → PowerDown = 00 two cycles after the first pulse; det_done pulses once; rx_present = 1.
- PHY returns RxStatus_0 = 3'b000 three times → det_attempts = 3; the FSM loops QUIET → DETECT; rx_present stays 0.
- No PhyStatus in DETECT → det_timeout = 1 at cycle 16; TxDetectRx_Loopback deasserted; FSM returns to QUIET.
- link_en dropped mid-DETECT → TxDetectRx_Loopback held until PhyStatus arrives, then the FSM goes to IDLE.
- ffs_plol pulsed in LINK_UP → RST_WAIT next cycle; PowerDown = 10; rx_present = 0; det_attempts preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module : pipe_pkg
// Brief  : PIPE power-state and RxStatus codes, plus the receiver-detect state
//          encoding shared with the LTSSM debug mux.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] PD_P0  = 2'b00;
  localparam logic [1:0] PD_P0S = 2'b01;
  localparam logic [1:0] PD_P1  = 2'b10;
  localparam logic [1:0] PD_P2  = 2'b11;

  localparam logic [2:0] RXSTAT_RXDET = 3'b011;

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_IDLE     = 3'd1,
    ST_QUIET    = 3'd2,
    ST_DETECT   = 3'd3,
    ST_DET_END  = 3'd4,
    ST_P0_REQ   = 3'd5,
    ST_LINK_UP  = 3'd6
  } rxdet_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_timer.sv
//------------------------------------------------------------------------------
// Module : pipe_timer
// Brief  : Loadable down-counter; done is high on the Nth cycle after a load of N,
//          counting the load cycle as the first.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pipe_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cur;

  // The load cycle already counts as N-1, so a registered load costs no latency.
  always_comb begin
    w_cur = load ? (len - c_one) : r_cnt;
    done  = (w_cur == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cur != '0) begin
      r_cnt <= w_cur - c_one;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_rxdet_seq.sv
//------------------------------------------------------------------------------
// Module : pipe_rxdet_seq
// Brief  : Receiver-detect and power-state sequencer for the x1 ECP3 PIPE PHY:
//          Detect.Quiet -> Detect.Active -> P0 entry handshake.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pipe_rxdet_seq
  import pipe_pkg::*;
#(
  parameter int QUIET_CYCLES   = 1500000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 21
) (
  input  logic       PCLK,
  input  logic       RESET_n,
  input  logic       link_en,
  input  logic       ffs_plol,
  input  logic       PhyStatus,
  input  logic [2:0] RxStatus_0,
  output logic [1:0] PowerDown,
  output logic       TxDetectRx_Loopback,
  output logic       TxElecIdle_0,
  output logic       rx_present,
  output logic       det_done,
  output logic       det_timeout,
  output logic [7:0] det_attempts,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] c_quiet_len   = CNT_W'(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] c_timeout_len = CNT_W'(TIMEOUT_CYCLES);

  rxdet_state_t     r_state;
  logic [1:0]       r_power_down;
  logic             r_tx_det;
  logic             r_tx_elec_idle;
  logic             r_rx_present;
  logic             r_det_done;
  logic             r_det_timeout;
  logic [7:0]       r_det_attempts;
  logic             r_found;
  logic             r_tmr_load;
  logic [CNT_W-1:0] r_tmr_len;
  logic             w_tmr_done;

  pipe_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (PCLK),
    .rst_n (RESET_n),
    .load  (r_tmr_load),
    .len   (r_tmr_len),
    .done  (w_tmr_done)
  );

  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state        <= ST_RST_WAIT;
      r_power_down   <= PD_P1;
      r_tx_det       <= 1'b0;
      r_tx_elec_idle <= 1'b1;
      r_rx_present   <= 1'b0;
      r_det_done     <= 1'b0;
      r_det_timeout  <= 1'b0;
      r_det_attempts <= 8'd0;
      r_found        <= 1'b0;
      r_tmr_load     <= 1'b0;
      r_tmr_len      <= c_quiet_len;
    end else begin
      r_det_done <= 1'b0;
      r_tmr_load <= 1'b0;
      // PLL loss of lock restarts the bring-up but keeps the diagnostics.
      if (ffs_plol && (r_state != ST_RST_WAIT)) begin
        r_state        <= ST_RST_WAIT;
        r_power_down   <= PD_P1;
        r_tx_det       <= 1'b0;
        r_tx_elec_idle <= 1'b1;
        r_rx_present   <= 1'b0;
        r_found        <= 1'b0;
      end else begin
        case (r_state)
          ST_RST_WAIT: begin
            if (!PhyStatus && !ffs_plol) r_state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (link_en) begin
              r_state    <= ST_QUIET;
              r_tmr_load <= 1'b1;
              r_tmr_len  <= c_quiet_len;
            end
          end
          ST_QUIET: begin
            if (!link_en) begin
              r_state <= ST_IDLE;
            end else if (w_tmr_done) begin
              r_state    <= ST_DETECT;
              r_tx_det   <= 1'b1;
              r_tmr_load <= 1'b1;
              r_tmr_len  <= c_timeout_len;
            end
          end
          ST_DETECT: begin
            if (PhyStatus) begin
              r_found  <= (RxStatus_0 == RXSTAT_RXDET);
              r_tx_det <= 1'b0;
              r_state  <= ST_DET_END;
            end else if (w_tmr_done) begin
              r_found       <= 1'b0;
              r_tx_det      <= 1'b0;
              r_det_timeout <= 1'b1;
              r_state       <= ST_DET_END;
            end
          end
          ST_DET_END: begin
            if (!r_found && (r_det_attempts != 8'hFF)) begin
              r_det_attempts <= r_det_attempts + 8'd1;
            end
            // A link_en drop seen during DETECT takes effect here.
            if (!link_en) begin
              r_state <= ST_IDLE;
            end else if (r_found) begin
              r_state      <= ST_P0_REQ;
              r_power_down <= PD_P0;
              r_tmr_load   <= 1'b1;
              r_tmr_len    <= c_timeout_len;
            end else begin
              r_state    <= ST_QUIET;
              r_tmr_load <= 1'b1;
              r_tmr_len  <= c_quiet_len;
            end
          end
          ST_P0_REQ: begin
            if (PhyStatus) begin
              r_state      <= ST_LINK_UP;
              r_rx_present <= 1'b1;
              r_det_done   <= 1'b1;
            end else if (w_tmr_done) begin
              r_det_timeout <= 1'b1;
              r_power_down  <= PD_P1;
              if (link_en) begin
                r_state    <= ST_QUIET;
                r_tmr_load <= 1'b1;
                r_tmr_len  <= c_quiet_len;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          ST_LINK_UP: begin
            if (!link_en) begin
              r_state      <= ST_IDLE;
              r_power_down <= PD_P1;
              r_rx_present <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_RST_WAIT;
          end
        endcase
      end
    end
  end

  assign PowerDown           = r_power_down;
  assign TxDetectRx_Loopback = r_tx_det;
  assign TxElecIdle_0        = r_tx_elec_idle;
  assign rx_present          = r_rx_present;
  assign det_done            = r_det_done;
  assign det_timeout         = r_det_timeout;
  assign det_attempts        = r_det_attempts;
  assign state_o             = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipe_rxdet_seq.sv
//------------------------------------------------------------------------------
// Module : tb_pipe_rxdet_seq
// Brief  : Directed cycle table plus hand sequences for pipe_rxdet_seq.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_rxdet_seq;
  import pipe_pkg::*;

  localparam int QUIET_CYCLES   = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 21;

  logic       PCLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       link_en = 1'b0;
  logic       ffs_plol = 1'b0;
  logic       PhyStatus = 1'b1;
  logic [2:0] RxStatus_0 = 3'b000;
  logic [1:0] PowerDown;
  logic       TxDetectRx_Loopback;
  logic       TxElecIdle_0;
  logic       rx_present;
  logic       det_done;
  logic       det_timeout;
  logic [7:0] det_attempts;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_rxdet_seq #(
    .QUIET_CYCLES   (QUIET_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .PCLK                (PCLK),
    .RESET_n             (RESET_n),
    .link_en             (link_en),
    .ffs_plol            (ffs_plol),
    .PhyStatus           (PhyStatus),
    .RxStatus_0          (RxStatus_0),
    .PowerDown           (PowerDown),
    .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .TxElecIdle_0        (TxElecIdle_0),
    .rx_present          (rx_present),
    .det_done            (det_done),
    .det_timeout         (det_timeout),
    .det_attempts        (det_attempts),
    .state_o             (state_o)
  );

  always #4 PCLK = ~PCLK;

  typedef struct {
    logic       le;
    logic       plol;
    logic       ps;
    logic [2:0] rxs;
    logic [2:0] st;
    logic [1:0] pd;
    logic       txd;
    logic       rxp;
    logic       dn;
    logic       tmo;
    logic [7:0] att;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic le, input logic plol, input logic ps,
                              input logic [2:0] rxs, input logic [2:0] st,
                              input logic [1:0] pd, input logic txd, input logic rxp,
                              input logic dn, input logic tmo, input logic [7:0] att);
    vec_t v;
    v.le = le; v.plol = plol; v.ps = ps; v.rxs = rxs;
    v.st = st; v.pd = pd; v.txd = txd; v.rxp = rxp;
    v.dn = dn; v.tmo = tmo; v.att = att;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_out(input string name, input logic [2:0] st, input logic [1:0] pd,
                           input logic txd, input logic rxp, input logic dn,
                           input logic tmo, input logic [7:0] att);
    logic [17:0] act;
    logic [17:0] exp;
    act = {state_o, PowerDown, TxDetectRx_Loopback, TxElecIdle_0, rx_present,
           det_done, det_timeout, det_attempts};
    exp = {st, pd, txd, 1'b1, rxp, dn, tmo, att};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d pd=%b txd=%b ei=%b rxp=%b done=%b tmo=%b att=%0d, want st=%0d pd=%b txd=%b ei=1 rxp=%b done=%b tmo=%b att=%0d",
               name, state_o, PowerDown, TxDetectRx_Loopback, TxElecIdle_0, rx_present,
               det_done, det_timeout, det_attempts, st, pd, txd, rxp, dn, tmo, att);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string name);
    int n;
    n = 0;
    while (state_o !== s && n < max) begin
      tick();
      n++;
    end
    n_checks++;
    if (state_o !== s) begin
      n_fail++;
      $display("FAIL %s: state %0d after %0d cycles, want %0d", name, state_o, n, s);
    end
  endtask

  task automatic count_in_state(input logic [2:0] s, output int n, output int tmo_early);
    n = 0;
    tmo_early = 0;
    while (state_o == s && n < 40) begin
      if (det_timeout !== 1'b0) tmo_early = 1;
      n++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int early;

    // Reset held with PhyStatus high (PHY still in reset).
    repeat (3) tick();
    check_out("reset_values", ST_RST_WAIT, PD_P1, 0, 0, 0, 0, 8'd0);
    RESET_n = 1'b1;

    // Main bring-up: 5 cycles of PhyStatus high, quiet dwell, found detect, P0 ack, drop.
    for (int i = 0; i < 5; i++) add(1, 0, 1, 3'b000, ST_RST_WAIT, PD_P1, 0, 0, 0, 0, 8'd0);
    add(1, 0, 0, 3'b000, ST_IDLE,    PD_P1, 0, 0, 0, 0, 8'd0);
    add(1, 0, 0, 3'b000, ST_QUIET,   PD_P1, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 3'b000, ST_QUIET, PD_P1, 0, 0, 0, 0, 8'd0);
    add(1, 0, 0, 3'b000, ST_DETECT,  PD_P1, 1, 0, 0, 0, 8'd0);
    add(1, 0, 0, 3'b000, ST_DETECT,  PD_P1, 1, 0, 0, 0, 8'd0);
    add(1, 0, 1, 3'b011, ST_DET_END, PD_P1, 0, 0, 0, 0, 8'd0);
    add(1, 0, 0, 3'b000, ST_P0_REQ,  PD_P0, 0, 0, 0, 0, 8'd0);
    add(1, 0, 0, 3'b000, ST_P0_REQ,  PD_P0, 0, 0, 0, 0, 8'd0);
    add(1, 0, 0, 3'b000, ST_P0_REQ,  PD_P0, 0, 0, 0, 0, 8'd0);
    add(1, 0, 1, 3'b000, ST_LINK_UP, PD_P0, 0, 1, 1, 0, 8'd0);
    add(1, 0, 0, 3'b000, ST_LINK_UP, PD_P0, 0, 1, 0, 0, 8'd0);
    add(1, 0, 1, 3'b000, ST_LINK_UP, PD_P0, 0, 1, 0, 0, 8'd0);
    add(0, 0, 0, 3'b000, ST_IDLE,    PD_P1, 0, 0, 0, 0, 8'd0);
    add(0, 0, 1, 3'b000, ST_IDLE,    PD_P1, 0, 0, 0, 0, 8'd0);

    foreach (vecs[i]) begin
      link_en    = vecs[i].le;
      ffs_plol   = vecs[i].plol;
      PhyStatus  = vecs[i].ps;
      RxStatus_0 = vecs[i].rxs;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].pd, vecs[i].txd,
                vecs[i].rxp, vecs[i].dn, vecs[i].tmo, vecs[i].att);
    end

    // Three detects with no receiver.
    PhyStatus = 1'b0;
    link_en   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_state(ST_DETECT, 20, "nofind_reach_detect");
      PhyStatus = 1'b1; RxStatus_0 = 3'b000;
      tick();
      check_out("nofind_det_end", ST_DET_END, PD_P1, 0, 0, 0, 0, 8'(k - 1));
      PhyStatus = 1'b0;
      tick();
      check_out("nofind_requiet", ST_QUIET, PD_P1, 0, 0, 0, 0, 8'(k));
    end

    // No PhyStatus in DETECT: timeout after 16 cycles.
    wait_state(ST_DETECT, 20, "tmo_reach_detect");
    count_in_state(ST_DETECT, n, early);
    check_int("detect_timeout_cycles", n, TIMEOUT_CYCLES);
    check_int("detect_timeout_not_early", early, 0);
    check_out("timeout_det_end", ST_DET_END, PD_P1, 0, 0, 0, 1, 8'd3);
    tick();
    check_out("timeout_requiet", ST_QUIET, PD_P1, 0, 0, 0, 1, 8'd4);

    // link_en dropped mid-DETECT: handshake finishes first.
    wait_state(ST_DETECT, 20, "drop_reach_detect");
    link_en = 1'b0;
    repeat (3) tick();
    check_out("drop_held_detect", ST_DETECT, PD_P1, 1, 0, 0, 1, 8'd4);
    PhyStatus = 1'b1; RxStatus_0 = 3'b000;
    tick();
    check_out("drop_det_end", ST_DET_END, PD_P1, 0, 0, 0, 1, 8'd4);
    PhyStatus = 1'b0;
    tick();
    check_out("drop_idle", ST_IDLE, PD_P1, 0, 0, 0, 1, 8'd5);

    // Link up, then PLL loss of lock.
    link_en = 1'b1;
    wait_state(ST_DETECT, 20, "plol_reach_detect");
    PhyStatus = 1'b1; RxStatus_0 = 3'b011;
    tick();
    check_out("plol_det_end", ST_DET_END, PD_P1, 0, 0, 0, 1, 8'd5);
    PhyStatus = 1'b0;
    tick();
    check_out("plol_p0_req", ST_P0_REQ, PD_P0, 0, 0, 0, 1, 8'd5);
    PhyStatus = 1'b1;
    tick();
    check_out("plol_link_up", ST_LINK_UP, PD_P0, 0, 1, 1, 1, 8'd5);
    PhyStatus = 1'b0; ffs_plol = 1'b1;
    tick();
    check_out("plol_rst_wait", ST_RST_WAIT, PD_P1, 0, 0, 0, 1, 8'd5);
    ffs_plol = 1'b0;
    tick();
    check_out("plol_idle", ST_IDLE, PD_P1, 0, 0, 0, 1, 8'd5);

    // P0 request never acknowledged.
    wait_state(ST_DETECT, 20, "p0tmo_reach_detect");
    PhyStatus = 1'b1; RxStatus_0 = 3'b011;
    tick();
    PhyStatus = 1'b0;
    tick();
    check_out("p0tmo_p0_req", ST_P0_REQ, PD_P0, 0, 0, 0, 1, 8'd5);
    count_in_state(ST_P0_REQ, n, early);
    check_int("p0_timeout_cycles", n, TIMEOUT_CYCLES);
    check_out("p0tmo_requiet", ST_QUIET, PD_P1, 0, 0, 0, 1, 8'd5);

    // Fresh reset, then PhyStatus on the same cycle as timer expiry.
    RESET_n = 1'b0;
    PhyStatus = 1'b1;
    tick();
    check_out("reset2_values", ST_RST_WAIT, PD_P1, 0, 0, 0, 0, 8'd0);
    PhyStatus = 1'b0;
    RESET_n = 1'b1;
    tick();
    check_out("reset2_idle", ST_IDLE, PD_P1, 0, 0, 0, 0, 8'd0);
    wait_state(ST_DETECT, 20, "race_reach_detect");
    repeat (TIMEOUT_CYCLES - 1) tick();
    check_out("race_last_detect", ST_DETECT, PD_P1, 1, 0, 0, 0, 8'd0);
    PhyStatus = 1'b1; RxStatus_0 = 3'b000;
    tick();
    check_out("race_phystatus_wins", ST_DET_END, PD_P1, 0, 0, 0, 0, 8'd0);
    PhyStatus = 1'b0;
    tick();
    check_out("race_requiet", ST_QUIET, PD_P1, 0, 0, 0, 0, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
